eh2_dccm_store_buf: RTL

Four-entry FIFO store buffer in front of the DCCM write port of the memory wrapper. It accepts full-word stores from the LSU commit stage and drains them into the DCCM whenever the single-ported DCCM is not being read. It arbitrates LSU loads onto the DCCM read port. Loads to an address still held in the buffer get the buffered data forwarded, youngest entry first, so they never observe stale SRAM contents.

---
 rtl/eh2_dccm_store_buf.sv | 110 +++++++++++
 1 files changed

// File: rtl/eh2_dccm_store_buf.sv
// eh2_dccm_store_buf: four-entry FIFO store buffer in front of the DCCM write port.
// Drains committed stores into the single-ported DCCM whenever loads leave it idle.
// Switches to drain priority when the buffer is full or a flush is requested.
// Forwards the youngest buffered data to loads that hit a buffered word address.
module eh2_dccm_store_buf #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        st_valid,
  input  logic [DCCM_BITS-1:0]        st_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data,
  output logic                        st_ready,
  input  logic                        ld_valid,
  input  logic [DCCM_BITS-1:0]        ld_addr,
  output logic                        ld_ready,
  output logic                        ld_fwd_hit,
  output logic [DCCM_FDATA_WIDTH-1:0] ld_fwd_data,
  input  logic                        wb_flush,
  output logic                        wb_empty,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DCCM_BITS-1:0]        addr_q [DEPTH];
  logic [DCCM_FDATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            count_q;

  logic full;
  logic drain;
  logic push;
  logic [PTR_W-1:0] fwd_idx;

  // Occupancy, handshake and port arbitration
  assign full      = (count_q == CNT_W'(DEPTH));
  assign wb_empty  = (count_q == '0);
  assign st_ready  = ~full & ~wb_flush;
  assign push      = st_valid & st_ready;
  assign drain     = ~wb_empty & (~ld_valid | full | wb_flush);
  assign ld_ready  = ld_valid & ~drain;
  assign dccm_wren = drain;
  assign dccm_rden = ld_ready;

  // Both DCCM halves see the same head entry and load address
  assign dccm_wr_addr_lo = addr_q[rd_ptr_q];
  assign dccm_wr_addr_hi = addr_q[rd_ptr_q];
  assign dccm_wr_data_lo = data_q[rd_ptr_q];
  assign dccm_wr_data_hi = data_q[rd_ptr_q];
  assign dccm_rd_addr_lo = ld_addr;
  assign dccm_rd_addr_hi = ld_addr;

  // Forwarding: walk entries oldest to youngest so the youngest valid match wins
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = '0;
    fwd_idx     = rd_ptr_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (addr_q[fwd_idx][DCCM_BITS-1:2] == ld_addr[DCCM_BITS-1:2])) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Entry payload storage, written at the tail on push
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drain) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
